// File: rtl/mult_div_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
package mult_div_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration: radix-2 Booth step (MULT) or restoring
// subtract/shift step on magnitudes (DIV) over a shared {hi, lo, q-1} accumulator.
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH:0]   acc_o
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             qm1;
  logic [WIDTH:0]   bsum;
  logic [2*WIDTH:0] booth_next;
  logic [WIDTH-1:0] s_lo;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [2*WIDTH:0] div_next;

  assign hi  = acc_i[2*WIDTH:WIDTH+1];
  assign lo  = acc_i[WIDTH:1];
  assign qm1 = acc_i[0];

  // Booth sum needs one guard bit: subtracting the most negative multiplicand
  // would otherwise overflow before the arithmetic shift.
  always_comb begin
    bsum = {hi[WIDTH-1], hi};
    case ({lo[0], qm1})
      2'b01:   bsum = {hi[WIDTH-1], hi} + {m_i[WIDTH-1], m_i};
      2'b10:   bsum = {hi[WIDTH-1], hi} - {m_i[WIDTH-1], m_i};
      default: bsum = {hi[WIDTH-1], hi};
    endcase
    booth_next = {bsum[WIDTH:1], bsum[0], lo[WIDTH-1:1], lo[0]};
  end

  // A bit shifted out of the remainder top means the partial value exceeds
  // any WIDTH-bit divisor, so the WIDTH-bit wrap-around difference is exact.
  always_comb begin
    s_lo     = {hi[WIDTH-2:0], lo[WIDTH-1]};
    ge       = hi[WIDTH-1] | (s_lo >= m_i);
    diff     = s_lo - m_i;
    div_next = {(ge ? diff : s_lo), lo[WIDTH-2:0], ge, 1'b0};
  end

  assign acc_o = is_div_i ? div_next : booth_next;

endmodule

// File: rtl/mult_div_ctrl.sv
// Multicycle sequencer for the shared multiply/divide unit: latches operands,
// iterates WIDTH steps, sign-corrects and holds the result in Hi/Lo.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_t             state_q, state_d;
  op_t                op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH:0]   acc_q;
  logic [2*WIDTH:0]   acc_step;
  logic               negq_q, negr_q, div0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               valid_op, is_div_req, b_zero;
  logic               accept, div0, run_step, fix;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;

  assign valid_op   = (Op == OP_MULT) || (Op == OP_DIV);
  assign is_div_req = (Op == OP_DIV);
  assign b_zero     = (B == '0);
  assign a_mag      = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag      = B[WIDTH-1] ? (~B + 1'b1) : B;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    div0     = 1'b0;
    run_step = 1'b0;
    fix      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start && valid_op) begin
          accept = 1'b1;
          if (is_div_req && b_zero) begin
            div0    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        run_step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_q == OP_DIV),
    .acc_i    (acc_q),
    .m_i      (m_q),
    .acc_o    (acc_step)
  );

  assign quo = acc_q[WIDTH:1];
  assign rem = acc_q[2*WIDTH:WIDTH+1];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_q   <= OP_MULT;
      cnt_q  <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= '0;
        div0_q <= div0;
        if (is_div_req) begin
          op_q   <= OP_DIV;
          m_q    <= b_mag;
          acc_q  <= {{WIDTH{1'b0}}, a_mag, 1'b0};
          negq_q <= A[WIDTH-1] ^ B[WIDTH-1];
          negr_q <= A[WIDTH-1];
        end else begin
          op_q   <= OP_MULT;
          m_q    <= A;
          acc_q  <= {{WIDTH{1'b0}}, B, 1'b0};
          negq_q <= 1'b0;
          negr_q <= 1'b0;
        end
      end else if (run_step) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end
      if (fix) begin
        if (op_q == OP_DIV) begin
          hi_q <= negr_q ? (~rem + 1'b1) : rem;
          lo_q <= negq_q ? (~quo + 1'b1) : quo;
        end else begin
          hi_q <= rem;
          lo_q <= quo;
        end
      end
    end
  end

  assign Busy    = (state_q == RUN) || (state_q == FIX);
  assign Done    = (state_q == DONE);
  assign DivZero = Done && div0_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl against a plain-arithmetic reference model.
module tb_mult_div_ctrl;
  import mult_div_pkg::*;

  localparam int unsigned W = 32;
  localparam int LAT = W + 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [1:0]    Op = 2'b00;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          Busy, Done, DivZero;
  logic [W-1:0]  Hi, Lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always #5 Clk = ~Clk;

  mult_div_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  // Reference: full-precision signed arithmetic; division truncates toward zero.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ed = 1'b0;
    if (op == 2'b00) begin
      p = sa * sb;
      mhi = p[63:32];
      mlo = p[31:0];
    end else if (b == 32'd0) begin
      ed = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      mlo = q[31:0];
      mhi = r[31:0];
    end
    eh = mhi;
    el = mlo;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; Op = 2'($urandom_range(0, 3)); A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    while (Done !== 1'b1 && lat < 200) begin
      if (Busy === 1'b1) busy_n++;
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_n);
    @(negedge Clk);
    issue(op, a, b);
    wait_done(lat, busy_n);
  endtask

  task automatic test_reset;
    #1 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", Done); end
    tests++; if (DivZero !== 1'b0) begin fails++; $display("FAIL reset_divzero got=%b exp=0", DivZero); end
    tests++; if (Hi !== 32'd0) begin fails++; $display("FAIL reset_hi got=%h exp=0", Hi); end
    tests++; if (Lo !== 32'd0) begin fails++; $display("FAIL reset_lo got=%h exp=0", Lo); end
    Reset = 1'b1;
  endtask

  task automatic test_mult;
    logic [31:0] eh, el; logic ed; int lat, bn;
    model(2'b00, 32'd7, 32'hFFFFFFFD, eh, el, ed);
    do_op(2'b00, 32'd7, 32'hFFFFFFFD, lat, bn);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL mult_latency got=%0d exp=%0d", lat, LAT); end
    tests++; if (bn !== LAT) begin fails++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", bn, LAT); end
    tests++; if (Hi !== eh || eh !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got=%h exp=%h", Hi, eh); end
    tests++; if (Lo !== el || el !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_lo got=%h exp=%h", Lo, el); end
    tests++; if (DivZero !== 1'b0) begin fails++; $display("FAIL mult_divzero got=%b exp=0", DivZero); end
    @(negedge Clk);
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse got=%b exp=0", Done); end
  endtask

  task automatic test_div_signs;
    logic [31:0] eh, el; logic ed; int lat, bn;
    model(2'b01, 32'hFFFFFFF9, 32'd2, eh, el, ed);
    do_op(2'b01, 32'hFFFFFFF9, 32'd2, lat, bn);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL div_latency got=%0d exp=%0d", lat, LAT); end
    tests++; if (Lo !== el || el !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_lo got=%h exp=%h", Lo, el); end
    tests++; if (Hi !== eh || eh !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_hi got=%h exp=%h", Hi, eh); end
    tests++; if (DivZero !== 1'b0) begin fails++; $display("FAIL div_divzero got=%b exp=0", DivZero); end
    model(2'b01, 32'd7, 32'hFFFFFFFE, eh, el, ed);
    do_op(2'b01, 32'd7, 32'hFFFFFFFE, lat, bn);
    tests++; if (Lo !== el || el !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_negb_lo got=%h exp=%h", Lo, el); end
    tests++; if (Hi !== eh || eh !== 32'd1) begin fails++; $display("FAIL div_negb_hi got=%h exp=%h", Hi, eh); end
  endtask

  task automatic test_divzero;
    logic [31:0] eh, el; logic ed; int lat, bn;
    model(2'b00, 32'd3, 32'd5, eh, el, ed);
    do_op(2'b00, 32'd3, 32'd5, lat, bn);
    model(2'b01, 32'd1234, 32'd0, eh, el, ed);
    do_op(2'b01, 32'd1234, 32'd0, lat, bn);
    tests++; if (lat !== 0) begin fails++; $display("FAIL div0_latency got=%0d exp=0", lat); end
    tests++; if (DivZero !== ed) begin fails++; $display("FAIL div0_flag got=%b exp=%b", DivZero, ed); end
    tests++; if (Hi !== eh || eh !== 32'd0) begin fails++; $display("FAIL div0_hi_hold got=%h exp=%h", Hi, eh); end
    tests++; if (Lo !== el || el !== 32'd15) begin fails++; $display("FAIL div0_lo_hold got=%h exp=%h", Lo, el); end
    @(negedge Clk);
    tests++; if (Done !== 1'b0 || DivZero !== 1'b0) begin fails++; $display("FAIL div0_pulse got=%b%b exp=00", Done, DivZero); end
  endtask

  task automatic test_overflow;
    logic [31:0] eh, el; logic ed; int lat, bn;
    model(2'b01, 32'h80000000, 32'hFFFFFFFF, eh, el, ed);
    do_op(2'b01, 32'h80000000, 32'hFFFFFFFF, lat, bn);
    tests++; if (Lo !== el || el !== 32'h80000000) begin fails++; $display("FAIL ovf_div_lo got=%h exp=%h", Lo, el); end
    tests++; if (Hi !== eh || eh !== 32'd0) begin fails++; $display("FAIL ovf_div_hi got=%h exp=%h", Hi, eh); end
    tests++; if (DivZero !== 1'b0) begin fails++; $display("FAIL ovf_div_divzero got=%b exp=0", DivZero); end
    model(2'b00, 32'h80000000, 32'h80000000, eh, el, ed);
    do_op(2'b00, 32'h80000000, 32'h80000000, lat, bn);
    tests++; if (Hi !== eh || eh !== 32'h40000000) begin fails++; $display("FAIL ovf_mult_hi got=%h exp=%h", Hi, eh); end
    tests++; if (Lo !== el || el !== 32'd0) begin fails++; $display("FAIL ovf_mult_lo got=%h exp=%h", Lo, el); end
  endtask

  task automatic test_start_ignored;
    logic [31:0] eh, el; logic ed; int lat, bn;
    model(2'b01, 32'd1000003, 32'hFFFFFFF3, eh, el, ed);
    @(negedge Clk);
    issue(2'b01, 32'd1000003, 32'hFFFFFFF3);
    repeat (9) @(negedge Clk);
    Start = 1'b1; Op = 2'b00; A = 32'd99; B = 32'd77;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(lat, bn);
    tests++; if (lat + 10 !== LAT) begin fails++; $display("FAIL ignore_latency got=%0d exp=%0d", lat + 10, LAT); end
    tests++; if (Lo !== el) begin fails++; $display("FAIL ignore_lo got=%h exp=%h", Lo, el); end
    tests++; if (Hi !== eh) begin fails++; $display("FAIL ignore_hi got=%h exp=%h", Hi, eh); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] eh, el, a2, b2; logic ed; int lat, bn;
    a2 = $urandom; b2 = $urandom;
    model(2'b00, 32'hDEADBEEF, 32'h12345678, eh, el, ed);
    do_op(2'b00, 32'hDEADBEEF, 32'h12345678, lat, bn);
    tests++; if (Hi !== eh || Lo !== el) begin fails++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", Hi, Lo, eh, el); end
    model(2'b01, a2, b2, eh, el, ed);
    issue(2'b01, a2, b2);
    wait_done(lat, bn);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
    tests++; if (Hi !== eh || Lo !== el) begin fails++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", Hi, Lo, eh, el); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] eh, el; logic ed; int lat, bn, seen;
    @(negedge Clk);
    issue(2'b00, $urandom, $urandom);
    repeat (20) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    tests++; if (Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0) begin
      fails++; $display("FAIL midreset_flags got=%b%b%b exp=000", Busy, Done, DivZero); end
    tests++; if (Hi !== 32'd0 || Lo !== 32'd0) begin fails++; $display("FAIL midreset_hilo got=%h_%h exp=0_0", Hi, Lo); end
    mhi = '0; mlo = '0;
    @(negedge Clk);
    Reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midreset_quiet got=%0d exp=0", seen); end
    model(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, eh, el, ed);
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bn);
    tests++; if (lat !== LAT || Hi !== eh || Lo !== el) begin
      fails++; $display("FAIL midreset_recover got=%0d,%h_%h exp=%0d,%h_%h", lat, Hi, Lo, LAT, eh, el); end
  endtask

  task automatic test_invalid_op;
    int seen;
    seen = 0;
    for (int k = 2; k < 4; k++) begin
      @(negedge Clk);
      Start = 1'b1; Op = 2'(k); A = $urandom; B = 32'd0;
      repeat (3) begin
        @(negedge Clk);
        if (Busy === 1'b1 || Done === 1'b1) seen++;
      end
      Start = 1'b0;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL invalid_op_activity got=%0d exp=0", seen); end
    tests++; if (Hi !== mhi || Lo !== mlo) begin fails++; $display("FAIL invalid_op_hilo got=%h_%h exp=%h_%h", Hi, Lo, mhi, mlo); end
  endtask

  task automatic test_random;
    logic [31:0] eh, el, a, b; logic ed; logic [1:0] op; int lat, bn;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 32'($signed(8'($urandom))) : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($signed(4'($urandom)));
      model(op, a, b, eh, el, ed);
      do_op(op, a, b, lat, bn);
      tests++; if (lat !== (ed ? 0 : LAT)) begin fails++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, op, lat, ed ? 0 : LAT); end
      tests++; if (DivZero !== ed) begin fails++; $display("FAIL rnd%0d_divzero got=%b exp=%b", i, DivZero, ed); end
      tests++; if (Hi !== eh) begin fails++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, Hi, eh); end
      tests++; if (Lo !== el) begin fails++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, Lo, el); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_signs();
    test_divzero();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_invalid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Multicycle sequencer for the CPU's shared multiply/divide resource. It accepts a start request from the main Control FSM with two register operands, runs iterative signed multiplication (radix-2 Booth) or signed restoring division, and holds the result in internal Hi/Lo registers. Hi/Lo feed the MemToReg mux (MFHI/MFLO path). Done and DivZero feed back to Control for stall release and the exception path.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  reset: asynchronous, active-low.
Start  input  1  request; sampled only in IDLE or DONE.
Op  input  2  00 MULT, 01 DIV, 10/11 invalid.
A  input  WIDTH  multiplicand / dividend (from regA).
B  input  WIDTH  multiplier / divisor (from regB).
Busy  output  1  high in RUN and FIX.
Done  output  1  high for exactly one cycle (DONE state).
DivZero  output  1  high together with Done when DIV had B==0.
Hi  output  WIDTH  MULT product [63:32]; DIV remainder.
Lo  output  WIDTH  MULT product [31:0]; DIV quotient.

Behaviour:
- Reset (Reset=0, any time, including mid-operation): state=IDLE; Busy=0, Done=0, DivZero=0, Hi=0, Lo=0; counter and working registers cleared. Operation resumes only after Reset returns to 1 and a new Start arrives.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE, accepting a request:
  - Start=1 with valid Op at edge k latches A, B, Op and clears the counter.
  - Next state is RUN, except DIV with B==0, which goes straight to DONE with DivZero=1.
  - Start=0 or invalid Op: go to or stay in IDLE; DONE always leaves after one cycle.
  - A Start in DONE is accepted, so back-to-back operations are allowed.
- RUN: one iteration per edge for WIDTH edges (counter 0..WIDTH-1). At the edge where counter==WIDTH-1, go to FIX.
  - MULT: Booth step on a 2*WIDTH+1 accumulator.
  - DIV: restoring step on magnitudes |A| and |B|; signs are recorded at latch time.
- FIX: apply sign correction.
  - Quotient is negated if the signs of A and B differ (truncation toward zero).
  - Remainder takes the sign of A.
  - Hi/Lo are written at this edge. Next state is DONE.
- Latency: Done is visible after edge k+WIDTH+1, i.e. 33 cycles for WIDTH=32. Divide-by-zero gives Done after edge k (1 cycle).
- Hi/Lo hold their values until the next FIX write or reset. On divide-by-zero, Hi/Lo are unchanged.
- Start during RUN/FIX is ignored, and operands are not re-sampled. A and B may change freely after the latch edge.
- Overflow case 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0, DivZero=0, no other flag. MULT never overflows (full 64-bit result).
- All arithmetic is two's complement; magnitude of 0x80000000 is handled in a WIDTH+1-bit intermediate.
- DivZero is low whenever Done is low.

Decomposition:
- Package mult_div_pkg holds:
  - the op_t enum (OP_MULT=2'b00, OP_DIV=2'b01);
  - the state_t enum (IDLE, RUN, FIX, DONE);
  - the default WIDTH constant.
- One natural sub-module: mult_div_step, a combinational single-iteration unit (Booth add/sub/shift or restoring subtract/shift selected by Op). The sequential FSM, counter and Hi/Lo registers stay in mult_div_ctrl.

Test Plan:
- MULT A=7, B=0xFFFFFFFD (-3) -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done one cycle, 33 cycles after the Start edge; Busy high for 32+1 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF, DivZero=0; then DIV A=7, B=0xFFFFFFFE -> Lo=0xFFFFFFFD, Hi=1.
- DIV with B=0 after a prior MULT 3*5 -> Done and DivZero one cycle after Start; Hi=0, Lo=15 retained.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0; MULT 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0.
- Start pulsed with new operands at RUN cycle 10 -> ignored, result matches first operands; Start held in DONE -> second op accepted, Done again 33 cycles later.
- Reset asserted at RUN cycle 20 -> Busy, Done, DivZero, Hi, Lo all 0 immediately (asynchronous); after release, no Done until a new Start.
